// File: rtl/range_pkg.sv
// Shared encodings for the range classifier / level generator pair.
// Setpoints sit at the centre of each class band: Q, 4Q and 7Q with Q = 2^(N-3).
package range_pkg;

    typedef enum logic [1:0] {
        CLASS_LOW     = 2'b00,
        CLASS_MID     = 2'b01,
        CLASS_HIGH    = 2'b10,
        CLASS_ILLEGAL = 2'b11
    } cls_e;

    typedef enum logic {
        HOLD = 1'b0,
        RAMP = 1'b1
    } state_e;

    function automatic int unsigned setpoint(input int unsigned n, input cls_e c);
        int unsigned q;
        q = 32'd1 << (n - 3);
        case (c)
            CLASS_LOW:  return q;
            CLASS_HIGH: return 7 * q;
            default:    return 4 * q;
        endcase
    endfunction

endpackage

// File: rtl/range_classifier.sv
// Maps the two level MSBs onto the class encoding: bottom quarter, middle half, top quarter.
module range_classifier
    import range_pkg::*;
(
    input  logic [1:0] msb_i,
    output logic [1:0] class_o
);

    always_comb begin
        class_o = CLASS_MID;
        case (msb_i)
            2'b00:   class_o = CLASS_LOW;
            2'b11:   class_o = CLASS_HIGH;
            default: class_o = CLASS_MID;
        endcase
    end

endmodule

// File: rtl/range_level_generator.sv
// Slews an N-bit level one LSB every STEP_DIV cycles towards the setpoint of the
// requested class, then holds it; requests are only taken while holding.
module range_level_generator
    import range_pkg::*;
#(
    parameter int N        = 7,
    parameter int STEP_DIV = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [1:0]   req_class_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    output logic [N-1:0] level_o,
    output logic [1:0]   level_class_o,
    output logic         settled_o,
    output logic         req_err_o
);

    localparam int            PW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PSC_TC = PW'(STEP_DIV - 1);

    if (N < 3) begin : g_bad_n
        $error("range_level_generator: N must be >= 3");
    end
    if (STEP_DIV < 1) begin : g_bad_div
        $error("range_level_generator: STEP_DIV must be >= 1");
    end

    state_e        state_q;
    cls_e          act_q;
    logic          dir_up_q;
    logic [N-1:0]  level_q;
    logic [PW-1:0] psc_q;
    logic          err_q;

    logic [N-1:0]  sp_req;
    logic [N-1:0]  sp_act;
    logic [N-1:0]  level_d;

    assign sp_req  = N'(setpoint(N, cls_e'(req_class_i)));
    assign sp_act  = N'(setpoint(N, act_q));
    // Setpoints are interior, so the stepped value can never wrap.
    assign level_d = dir_up_q ? level_q + 1'b1 : level_q - 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= HOLD;
            act_q    <= CLASS_MID;
            dir_up_q <= 1'b1;
            level_q  <= N'(setpoint(N, CLASS_MID));
            psc_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                HOLD: begin
                    if (req_valid_i) begin
                        if (req_class_i == CLASS_ILLEGAL) begin
                            err_q <= 1'b1;
                        end else begin
                            act_q <= cls_e'(req_class_i);
                            psc_q <= '0;
                            if (level_q != sp_req) begin
                                state_q  <= RAMP;
                                dir_up_q <= (level_q < sp_req);
                            end
                        end
                    end
                end
                RAMP: begin
                    if (psc_q == PSC_TC) begin
                        psc_q   <= '0;
                        level_q <= level_d;
                        if (level_d == sp_act) state_q <= HOLD;
                    end else begin
                        psc_q <= psc_q + 1'b1;
                    end
                end
                default: state_q <= HOLD;
            endcase
        end
    end

    range_classifier u_cls (
        .msb_i   (level_q[N-1:N-2]),
        .class_o (level_class_o)
    );

    assign level_o     = level_q;
    assign req_ready_o = (state_q == HOLD);
    assign settled_o   = (state_q == HOLD);
    assign req_err_o   = err_q;

endmodule

// File: tb/tb_range_level_generator.sv
// Bench for range_level_generator: STEP_DIV=4 and STEP_DIV=1 instances, settle scoreboard,
// table of class requests and hand-written timing, illegal and reset sequences.
module tb_range_level_generator;

    localparam int N = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst4_n = 1'b1, rst1_n = 1'b1;
    logic [1:0]   cls4 = 2'b01, cls1 = 2'b01;
    logic         v4 = 1'b0, v1 = 1'b0;
    logic         rdy4, set4, err4, rdy1, set1, err1;
    logic [N-1:0] lvl4, lvl1;
    logic [1:0]   lc4, lc1;

    range_level_generator #(.N(N), .STEP_DIV(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst4_n), .req_class_i(cls4), .req_valid_i(v4),
        .req_ready_o(rdy4), .level_o(lvl4), .level_class_o(lc4),
        .settled_o(set4), .req_err_o(err4)
    );

    range_level_generator #(.N(N), .STEP_DIV(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst1_n), .req_class_i(cls1), .req_valid_i(v1),
        .req_ready_o(rdy1), .level_o(lvl1), .level_class_o(lc1),
        .settled_o(set1), .req_err_o(err1)
    );

    int total = 0, bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int mcls(input int l);
        if (l < 32) return 0;
        if (l >= 96) return 2;
        return 1;
    endfunction

    typedef struct {int lvl; int cyc;} exp_t;
    exp_t sb[$];
    exp_t e;
    int   model4 = 64;
    logic set4_prev = 1'b1;

    always @(negedge clk) begin
        if (rst4_n) begin
            chk("class4", lc4, mcls(lvl4));
            if (set4 && !set4_prev) begin
                if (sb.size() == 0) chk("settle_without_request", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    chk("settle_lvl", lvl4, e.lvl);
                    chk("settle_cyc", cyc, e.cyc);
                end
            end
        end
        if (rst1_n) chk("class1", lc1, mcls(lvl1));
        set4_prev = set4;
    end

    task automatic do_req4(input logic [1:0] c, input int sp);
        int d;
        @(negedge clk);
        cls4 = c;
        v4   = 1'b1;
        d = (sp > model4) ? sp - model4 : model4 - sp;
        if (d != 0) sb.push_back('{sp, cyc + 1 + d * 4});
        model4 = sp;
        @(posedge clk);
        #1 v4 = 1'b0;
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic req1(input logic [1:0] c, output int e0);
        @(negedge clk);
        cls1 = c;
        v1   = 1'b1;
        e0   = cyc + 1;
        @(posedge clk);
        #1 v1 = 1'b0;
    endtask

    task automatic settle1(input int e0, input int want, input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!set1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("s1_cyc", cyc, e0 + d);
        chk("s1_lvl", lvl1, want);
    endtask

    typedef struct {logic [1:0] cls; int sp;} vec_t;
    vec_t vt[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit same;
        int e0;
        vt[0] = '{2'b00, 16};
        vt[1] = '{2'b01, 64};
        vt[2] = '{2'b01, 64};
        vt[3] = '{2'b10, 112};
        vt[4] = '{2'b01, 64};

        #1 rst4_n = 1'b0; rst1_n = 1'b0;
        #1;
        chk("rst_lvl4", lvl4, 64);  chk("rst_cls4", lc4, 1);
        chk("rst_set4", set4, 1);   chk("rst_rdy4", rdy4, 1);  chk("rst_err4", err4, 0);
        chk("rst_lvl1", lvl1, 64);  chk("rst_set1", set1, 1);  chk("rst_err1", err1, 0);
        @(negedge clk);
        rst4_n = 1'b1; rst1_n = 1'b1;
        repeat (2) @(negedge clk);

        do_req4(2'b10, 112);
        @(negedge clk);
        chk("ramp_rdy", rdy4, 0); chk("ramp_set", set4, 0); chk("e0_lvl", lvl4, 64);
        repeat (3) @(negedge clk);
        chk("e0p3_lvl", lvl4, 64);
        @(negedge clk);
        chk("e0p4_lvl", lvl4, 65);
        repeat (4) @(negedge clk);
        chk("e0p8_lvl", lvl4, 66);
        @(negedge clk);
        cls4 = 2'b00; v4 = 1'b1;
        @(posedge clk);
        #1 v4 = 1'b0;
        @(negedge clk);
        chk("ignored_err", err4, 0); chk("ignored_rdy", rdy4, 0);
        drain4();
        @(negedge clk);
        chk("up_hold_lvl", lvl4, 112);

        for (int i = 0; i < 5; i++) begin
            same = (vt[i].sp == model4);
            do_req4(vt[i].cls, vt[i].sp);
            if (same) begin
                repeat (6) begin
                    @(negedge clk);
                    chk("same_settled", set4, 1);
                    chk("same_lvl", lvl4, vt[i].sp);
                end
            end else begin
                @(negedge clk);
                chk("vec_busy", rdy4, 0);
                drain4();
            end
            @(negedge clk);
            chk("vec_hold_lvl", lvl4, vt[i].sp);
        end

        @(negedge clk);
        cls4 = 2'b11; v4 = 1'b1;
        @(posedge clk);
        #1 v4 = 1'b0;
        @(negedge clk);
        chk("ill_err_hi", err4, 1); chk("ill_lvl", lvl4, 64);
        chk("ill_set", set4, 1);    chk("ill_cls", lc4, 1);
        @(negedge clk);
        chk("ill_err_lo", err4, 0); chk("ill_lvl2", lvl4, 64);

        req1(2'b10, e0);
        settle1(e0, 112, 48);
        req1(2'b01, e0);
        settle1(e0, 64, 48);
        req1(2'b10, e0);
        while (cyc < e0 + 20) @(negedge clk);
        chk("d1_mid_lvl", lvl1, 84);
        chk("d1_mid_set", set1, 0);
        #2 rst1_n = 1'b0;
        #1;
        chk("arst_lvl", lvl1, 64); chk("arst_cls", lc1, 1);
        chk("arst_set", set1, 1);  chk("arst_rdy", rdy1, 1); chk("arst_err", err1, 0);
        @(negedge clk);
        rst1_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_lvl", lvl1, 64); chk("post_rst_set", set1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
